// File: rtl/lbdr_pkg.sv
// lbdr_pkg: shared constants and types for the LBDR routing block.
//   Flit type codes, port index constants (N/E/W/S), bit positions of the
//   one-hot port_req vector {L,S,W,E,N} and the router FSM state enum.
package lbdr_pkg;

  localparam logic [2:0] FLIT_HEADER  = 3'd1;
  localparam logic [2:0] FLIT_PAYLOAD = 3'd2;
  localparam logic [2:0] FLIT_TAIL    = 3'd4;

  localparam logic [1:0] PORT_N = 2'd0;
  localparam logic [1:0] PORT_E = 2'd1;
  localparam logic [1:0] PORT_W = 2'd2;
  localparam logic [1:0] PORT_S = 2'd3;

  localparam int unsigned BIT_N = 0;
  localparam int unsigned BIT_E = 1;
  localparam int unsigned BIT_W = 2;
  localparam int unsigned BIT_S = 3;
  localparam int unsigned BIT_L = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

endpackage

// File: rtl/lbdr_route_comb.sv
// lbdr_route_comb: purely combinational LBDR route computation.
//   Compares current and destination coordinates, applies the minimal
//   routing equations with routing (rxy) and connectivity (cx) bits, and
//   reduces the result to a single one-hot request (lowest index wins).
//   Optional macro LBDR_DEROUTE_EN adds a deroute port taken from dr when
//   no minimal output is usable.
// Ports:
//   cur_addr  in  A_W  router address {y,x}
//   dst_addr  in  A_W  destination address {y,x}
//   rxy       in  8    routing bits, bit 0 = Rne
//   cx        in  4    connectivity bits, bit 0 = Cn
//   dr        in  8    deroute table (only with LBDR_DEROUTE_EN)
//   port_req  out 5    one-hot {L,S,W,E,N}, zero if no route exists
module lbdr_route_comb
  import lbdr_pkg::*;
#(
  parameter int unsigned X_W = 2,
  parameter int unsigned Y_W = 2,
  localparam int unsigned A_W = Y_W + X_W
) (
  input  logic [A_W-1:0] cur_addr,
  input  logic [A_W-1:0] dst_addr,
  input  logic [7:0]     rxy,
  input  logic [3:0]     cx,
`ifdef LBDR_DEROUTE_EN
  input  logic [7:0]     dr,
`endif
  output logic [4:0]     port_req
);

  logic [X_W-1:0] x_cur, x_dst;
  logic [Y_W-1:0] y_cur, y_dst;
  logic           n1, s1, e1, w1;
  logic [4:0]     min_req;
  logic [4:0]     cand;

  assign x_cur = cur_addr[X_W-1:0];
  assign y_cur = cur_addr[A_W-1:X_W];
  assign x_dst = dst_addr[X_W-1:0];
  assign y_dst = dst_addr[A_W-1:X_W];

  assign n1 = y_dst < y_cur;
  assign s1 = y_cur < y_dst;
  assign e1 = x_cur < x_dst;
  assign w1 = x_dst < x_cur;

  always_comb begin
    min_req        = '0;
    min_req[BIT_N] = ((n1 & ~e1 & ~w1) | (n1 & e1 & rxy[0]) | (n1 & w1 & rxy[1])) & cx[0];
    min_req[BIT_E] = ((e1 & ~n1 & ~s1) | (e1 & n1 & rxy[2]) | (e1 & s1 & rxy[3])) & cx[1];
    min_req[BIT_W] = ((w1 & ~n1 & ~s1) | (w1 & n1 & rxy[4]) | (w1 & s1 & rxy[5])) & cx[2];
    min_req[BIT_S] = ((s1 & ~e1 & ~w1) | (s1 & e1 & rxy[6]) | (s1 & w1 & rxy[7])) & cx[3];
    min_req[BIT_L] = ~n1 & ~e1 & ~w1 & ~s1;
  end

`ifdef LBDR_DEROUTE_EN
  logic [1:0] k;
  logic [1:0] p;

  always_comb begin
    if (n1)      k = PORT_N;
    else if (s1) k = PORT_S;
    else if (e1) k = PORT_E;
    else         k = PORT_W;
    p    = dr[2*k +: 2];
    cand = min_req;
    // Port index equals its port_req bit position for N/E/W/S.
    if (min_req == '0 && cx[p]) begin
      cand    = '0;
      cand[p] = 1'b1;
    end
  end
`else
  assign cand = min_req;
`endif

  // Isolate lowest set bit so the request stays one-hot.
  assign port_req = cand & (~cand + 5'd1);

endmodule

// File: rtl/lbdr_dr.sv
// lbdr_dr: LBDR router output-port selection with packet-level route hold.
//   Holds the configuration registers and the IDLE/ACTIVE FSM; a header in
//   IDLE latches a one-hot route that is held until an accepted tail.
//   Optional macro LBDR_DEROUTE_EN enables the deroute table register.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   cfg_we          configuration load strobe (honoured only in IDLE)
//   rxy_in, cx_in, dr_in, cur_addr_in   configuration values
//   flit_valid, flit_id, dst_addr, out_ready   flit interface
//   port_req        one-hot {L,S,W,E,N} route
//   route_valid     port_req holds an active route
//   err             one-cycle protocol/routing error pulse
module lbdr_dr
  import lbdr_pkg::*;
#(
  parameter int unsigned X_W = 2,
  parameter int unsigned Y_W = 2,
  localparam int unsigned A_W = Y_W + X_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cfg_we,
  input  logic [7:0]     rxy_in,
  input  logic [3:0]     cx_in,
  input  logic [7:0]     dr_in,
  input  logic [A_W-1:0] cur_addr_in,
  input  logic           flit_valid,
  input  logic [2:0]     flit_id,
  input  logic [A_W-1:0] dst_addr,
  input  logic           out_ready,
  output logic [4:0]     port_req,
  output logic           route_valid,
  output logic           err
);

  state_t         state, state_n;
  logic [4:0]     port_req_n;
  logic           route_valid_n;
  logic           err_n;
  logic           cfg_load;
  logic [7:0]     rxy_q;
  logic [3:0]     cx_q;
  logic [A_W-1:0] cur_q;
  logic [4:0]     route;

`ifdef LBDR_DEROUTE_EN
  logic [7:0] dr_q;

  always_ff @(posedge clk) begin
    if (rst || cfg_load) dr_q <= dr_in;
  end
`else
  logic unused_dr;
  assign unused_dr = ^dr_in;
`endif

  lbdr_route_comb #(
    .X_W(X_W),
    .Y_W(Y_W)
  ) u_route (
    .cur_addr(cur_q),
    .dst_addr(dst_addr),
    .rxy     (rxy_q),
    .cx      (cx_q),
`ifdef LBDR_DEROUTE_EN
    .dr      (dr_q),
`endif
    .port_req(route)
  );

  // Routing uses the registered configuration, so a header coinciding with
  // cfg_we sees the old values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      port_req    <= '0;
      route_valid <= 1'b0;
      err         <= 1'b0;
      rxy_q       <= rxy_in;
      cx_q        <= cx_in;
      cur_q       <= cur_addr_in;
    end else begin
      state       <= state_n;
      port_req    <= port_req_n;
      route_valid <= route_valid_n;
      err         <= err_n;
      if (cfg_load) begin
        rxy_q <= rxy_in;
        cx_q  <= cx_in;
        cur_q <= cur_addr_in;
      end
    end
  end

  always_comb begin
    state_n       = state;
    port_req_n    = port_req;
    route_valid_n = route_valid;
    err_n         = 1'b0;
    cfg_load      = 1'b0;
    unique case (state)
      IDLE: begin
        cfg_load = cfg_we;
        if (flit_valid) begin
          if (flit_id == FLIT_HEADER) begin
            if (route != '0) begin
              port_req_n    = route;
              route_valid_n = 1'b1;
              state_n       = ACTIVE;
            end else begin
              err_n = 1'b1;
            end
          end else begin
            err_n = 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (cfg_we) err_n = 1'b1;
        if (flit_valid) begin
          if (flit_id == FLIT_HEADER) begin
            err_n = 1'b1;
          end else if (flit_id == FLIT_TAIL && out_ready) begin
            port_req_n    = '0;
            route_valid_n = 1'b0;
            state_n       = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lbdr_dr.sv
module tb_lbdr_dr;
  import lbdr_pkg::*;

  logic       clk;
  logic       rst;
  logic       cfg_we;
  logic [7:0] rxy_in;
  logic [3:0] cx_in;
  logic [7:0] dr_in;
  logic [3:0] cur_addr_in;
  logic       flit_valid;
  logic [2:0] flit_id;
  logic [3:0] dst_addr;
  logic       out_ready;
  logic [4:0] port_req;
  logic       route_valid;
  logic       err;

  int checks = 0;
  int fails  = 0;

  lbdr_dr #(.X_W(2), .Y_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .rxy_in     (rxy_in),
    .cx_in      (cx_in),
    .dr_in      (dr_in),
    .cur_addr_in(cur_addr_in),
    .flit_valid (flit_valid),
    .flit_id    (flit_id),
    .dst_addr   (dst_addr),
    .out_ready  (out_ready),
    .port_req   (port_req),
    .route_valid(route_valid),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cfg_we     = 1'b0;
    flit_valid = 1'b0;
    flit_id    = FLIT_PAYLOAD;
    out_ready  = 1'b0;
  endtask

  task automatic send_tail();
    flit_valid = 1'b1; flit_id = FLIT_TAIL; out_ready = 1'b1;
    tick();
    idle_inputs();
  endtask

  task automatic test_reset();
    rst = 1'b1; idle_inputs(); dst_addr = 4'h0;
    rxy_in = 8'h3C; cx_in = 4'hF; dr_in = 8'h00; cur_addr_in = 4'h5;
    tick(); tick();
    rst = 1'b0;
    checks++; if (port_req !== 5'b00000) begin fails++; $display("FAIL reset_port_req: got %b expected 00000", port_req); end
    checks++; if (route_valid !== 1'b0) begin fails++; $display("FAIL reset_route_valid: got %b expected 0", route_valid); end
    checks++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b expected 0", err); end
  endtask

  task automatic test_basic_packet();
    flit_valid = 1'b1; flit_id = FLIT_HEADER; dst_addr = 4'h6;
    tick();
    checks++; if (port_req !== 5'b00010) begin fails++; $display("FAIL basic_header_port: got %b expected 00010", port_req); end
    checks++; if (route_valid !== 1'b1) begin fails++; $display("FAIL basic_header_valid: got %b expected 1", route_valid); end
    checks++; if (err !== 1'b0) begin fails++; $display("FAIL basic_header_err: got %b expected 0", err); end
    flit_id = FLIT_PAYLOAD; dst_addr = 4'h0; out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (port_req !== 5'b00010) begin fails++; $display("FAIL basic_payload_hold%0d: got %b expected 00010", i, port_req); end
    end
    flit_valid = 1'b0; flit_id = FLIT_TAIL;
    tick();
    checks++; if (port_req !== 5'b00010) begin fails++; $display("FAIL basic_gap_hold: got %b expected 00010", port_req); end
    send_tail();
    checks++; if (port_req !== 5'b00000) begin fails++; $display("FAIL basic_tail_port: got %b expected 00000", port_req); end
    checks++; if (route_valid !== 1'b0) begin fails++; $display("FAIL basic_tail_valid: got %b expected 0", route_valid); end
  endtask

  task automatic test_directions();
    logic [3:0] dsts [4] = '{4'h0, 4'h5, 4'hD, 4'h2};
    logic [4:0] exps [4] = '{5'b00100, 5'b10000, 5'b01000, 5'b00010};
    for (int i = 0; i < 4; i++) begin
      flit_valid = 1'b1; flit_id = FLIT_HEADER; dst_addr = dsts[i];
      tick();
      flit_valid = 1'b0;
      checks++; if (port_req !== exps[i]) begin fails++; $display("FAIL dir_dst%0h: got %b expected %b", dsts[i], port_req, exps[i]); end
      checks++; if (route_valid !== 1'b1) begin fails++; $display("FAIL dir_valid_dst%0h: got %b expected 1", dsts[i], route_valid); end
      send_tail();
    end
  endtask

  task automatic test_cfg_and_priority();
    // Header in the same cycle as cfg_we uses the old rxy (Rne=0): E.
    rxy_in = 8'h3D; cfg_we = 1'b1;
    flit_valid = 1'b1; flit_id = FLIT_HEADER; dst_addr = 4'h2;
    tick();
    idle_inputs();
    checks++; if (port_req !== 5'b00010) begin fails++; $display("FAIL cfg_same_cycle: got %b expected 00010", port_req); end
    send_tail();
    // With Rne=1 and Ren=1 both N and E are minimal; lowest index N wins.
    flit_valid = 1'b1; flit_id = FLIT_HEADER; dst_addr = 4'h2;
    tick();
    idle_inputs();
    checks++; if (port_req !== 5'b00001) begin fails++; $display("FAIL priority_ne: got %b expected 00001", port_req); end
    send_tail();
    rxy_in = 8'h3C; cfg_we = 1'b1;
    tick();
    idle_inputs();
  endtask

  task automatic test_deroute();
    cx_in = 4'hD; dr_in = 8'h0C; cfg_we = 1'b1;
    tick();
    idle_inputs();
    flit_valid = 1'b1; flit_id = FLIT_HEADER; dst_addr = 4'h6;
    tick();
    idle_inputs();
`ifdef LBDR_DEROUTE_EN
    checks++; if (port_req !== 5'b01000) begin fails++; $display("FAIL deroute_port: got %b expected 01000", port_req); end
    checks++; if (route_valid !== 1'b1) begin fails++; $display("FAIL deroute_valid: got %b expected 1", route_valid); end
    checks++; if (err !== 1'b0) begin fails++; $display("FAIL deroute_err: got %b expected 0", err); end
    send_tail();
`else
    checks++; if (port_req !== 5'b00000) begin fails++; $display("FAIL noroute_port: got %b expected 00000", port_req); end
    checks++; if (route_valid !== 1'b0) begin fails++; $display("FAIL noroute_valid: got %b expected 0", route_valid); end
    checks++; if (err !== 1'b1) begin fails++; $display("FAIL noroute_err: got %b expected 1", err); end
    tick();
    checks++; if (err !== 1'b0) begin fails++; $display("FAIL noroute_err_pulse: got %b expected 0", err); end
`endif
    // State must be IDLE in both builds: a payload now is a protocol error.
    flit_valid = 1'b1; flit_id = FLIT_PAYLOAD;
    tick();
    idle_inputs();
    checks++; if (err !== 1'b1) begin fails++; $display("FAIL deroute_state_idle: got %b expected 1", err); end
    cx_in = 4'hF; dr_in = 8'h00; cfg_we = 1'b1;
    tick();
    idle_inputs();
  endtask

  task automatic test_active_errors();
    flit_valid = 1'b1; flit_id = FLIT_HEADER; dst_addr = 4'h6;
    tick();
    dst_addr = 4'h0;
    tick();
    flit_valid = 1'b0;
    checks++; if (err !== 1'b1) begin fails++; $display("FAIL second_header_err: got %b expected 1", err); end
    checks++; if (port_req !== 5'b00010) begin fails++; $display("FAIL second_header_route: got %b expected 00010", port_req); end
    tick();
    checks++; if (err !== 1'b0) begin fails++; $display("FAIL second_header_pulse: got %b expected 0", err); end
    cur_addr_in = 4'hA; cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0; cur_addr_in = 4'h5;
    checks++; if (err !== 1'b1) begin fails++; $display("FAIL active_cfg_err: got %b expected 1", err); end
    flit_valid = 1'b1; flit_id = FLIT_TAIL; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (port_req !== 5'b00010) begin fails++; $display("FAIL tail_stall%0d: got %b expected 00010", i, port_req); end
      checks++; if (route_valid !== 1'b1) begin fails++; $display("FAIL tail_stall_valid%0d: got %b expected 1", i, route_valid); end
    end
    out_ready = 1'b1;
    tick();
    idle_inputs();
    checks++; if (route_valid !== 1'b0) begin fails++; $display("FAIL tail_release: got %b expected 0", route_valid); end
    // cur_addr must still be 5: dst 6 routes E (cur 0xA would give N).
    flit_valid = 1'b1; flit_id = FLIT_HEADER; dst_addr = 4'h6;
    tick();
    idle_inputs();
    checks++; if (port_req !== 5'b00010) begin fails++; $display("FAIL active_cfg_ignored: got %b expected 00010", port_req); end
    send_tail();
  endtask

  task automatic test_idle_errors();
    flit_valid = 1'b1; flit_id = FLIT_PAYLOAD;
    tick();
    flit_id = FLIT_TAIL; out_ready = 1'b1;
    checks++; if (err !== 1'b1) begin fails++; $display("FAIL idle_payload_err: got %b expected 1", err); end
    checks++; if (route_valid !== 1'b0) begin fails++; $display("FAIL idle_payload_valid: got %b expected 0", route_valid); end
    tick();
    idle_inputs();
    checks++; if (err !== 1'b1) begin fails++; $display("FAIL idle_tail_err: got %b expected 1", err); end
    checks++; if (port_req !== 5'b00000) begin fails++; $display("FAIL idle_tail_port: got %b expected 00000", port_req); end
    tick();
    checks++; if (err !== 1'b0) begin fails++; $display("FAIL idle_err_pulse: got %b expected 0", err); end
  endtask

  task automatic test_reset_mid_packet();
    flit_valid = 1'b1; flit_id = FLIT_HEADER; dst_addr = 4'h6;
    tick();
    flit_id = FLIT_PAYLOAD;
    checks++; if (route_valid !== 1'b1) begin fails++; $display("FAIL rst_mid_setup: got %b expected 1", route_valid); end
    cur_addr_in = 4'hA; rst = 1'b1;
    tick();
    rst = 1'b0; idle_inputs();
    checks++; if (port_req !== 5'b00000) begin fails++; $display("FAIL rst_mid_port: got %b expected 00000", port_req); end
    checks++; if (route_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_valid: got %b expected 0", route_valid); end
    checks++; if (err !== 1'b0) begin fails++; $display("FAIL rst_mid_err: got %b expected 0", err); end
    flit_valid = 1'b1; flit_id = FLIT_HEADER; dst_addr = 4'h6;
    tick();
    idle_inputs();
    checks++; if (port_req !== 5'b00001) begin fails++; $display("FAIL rst_reload_route: got %b expected 00001", port_req); end
    send_tail();
  endtask

  initial begin
    test_reset();
    test_basic_packet();
    test_directions();
    test_cfg_and_priority();
    test_deroute();
    test_active_errors();
    test_idle_errors();
    test_reset_mid_packet();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
